// File: rtl/d_flip_flop_16_bit.sv
// rtl/d_flip_flop_16_bit.sv - 16-bit parallel-load register with asynchronous active-low clear
//
// Purpose: basic 16-bit storage element of the single-cycle datapath
// (register-file entries, program/instruction registers). Built from 16
// identical bit cells, each a D flip-flop with a load/hold select.
//
// Ports:
//   clk   in   1   rising-edge clock for loads
//   clr   in   1   asynchronous active-low clear; forces Q to 0 while low
//   D     in  16   data to capture; bit i feeds cell i
//   LOAD  in   1   active-high load enable; 0 holds current contents
//   Q     out 16   stored value; driven only by the flip-flops

module d_flip_flop_16_bit (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] D,
    input  logic        LOAD,
    output logic [15:0] Q
);

    localparam int WIDTH = 16;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            logic cell_q;
            logic cell_d;

            // Load/hold select sits in front of the flop, so D and LOAD
            // only ever reach Q through a clock edge.
            assign cell_d = LOAD ? D[i] : cell_q;

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    cell_q <= 1'b0;
                end else begin
                    cell_q <= cell_d;
                end
            end

            assign Q[i] = cell_q;
        end
    endgenerate

endmodule

// File: tb/tb_d_flip_flop_16_bit.sv
// tb/tb_d_flip_flop_16_bit.sv - self-checking bench for d_flip_flop_16_bit

module tb_d_flip_flop_16_bit;

    logic        clk;
    logic        clr;
    logic [15:0] D;
    logic        LOAD;
    logic [15:0] Q;

    int          total;
    int          bad;
    logic [15:0] exp_q;

    d_flip_flop_16_bit dut (
        .clk  (clk),
        .clr  (clr),
        .D    (D),
        .LOAD (LOAD),
        .Q    (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, want, $time);
        end
    endtask

    // Reference: at each rising edge the register takes D when clear is
    // released and LOAD is high, otherwise keeps its value; clear wins.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!clr)      exp_q = 16'h0000;
        else if (LOAD) exp_q = D;
        #1;
        check_val(tag, Q, exp_q);
    endtask

    // Clear pulse of 3 time units placed between clock edges.
    task automatic clear_pulse(input string tag);
        clr = 1'b0;
        exp_q = 16'h0000;
        #1;
        check_val(tag, Q, exp_q);
        #2;
        clr = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] acc;
        total = 0;
        bad   = 0;
        clr   = 1'b1;
        LOAD  = 1'b0;
        D     = 16'h0000;
        exp_q = 16'h0000;

        // Reset state
        #2;
        clr = 1'b0;
        #1;
        check_val("reset", Q, 16'h0000);

        // Clear dominates load over several edges
        LOAD = 1'b1;
        D    = 16'hFFFF;
        for (int k = 0; k < 3; k++) tick("clear_hold");
        check_val("clear_final", Q, 16'h0000);
        clr = 1'b1;

        // Walking cumulative load
        acc = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            acc  = acc | (16'h0001 << k);
            D    = acc;
            LOAD = 1'b1;
            tick("walk");
        end
        check_val("walk_final", Q, 16'hFFFF);

        // Hold
        D    = 16'h00FF;
        LOAD = 1'b1;
        tick("hold_setup");
        LOAD = 1'b0;
        acc  = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            acc = acc | (16'h0100 << k);
            D   = acc;
            tick("hold");
        end
        check_val("hold_final", Q, 16'h00FF);

        // Edge sensitivity: D changes between edges do not reach Q
        LOAD = 1'b1;
        D    = 16'h1234;
        tick("edge_load");
        #2;
        D = 16'hABCD;
        #1;
        check_val("edge_mid", Q, 16'h1234);
        @(negedge clk);
        D = 16'h5555;
        #1;
        check_val("edge_fall", Q, 16'h1234);
        D = 16'hABCD;
        tick("edge_next");
        check_val("edge_final", Q, 16'hABCD);

        // Asynchronous clear mid-cycle, then reload
        D    = 16'hFFFF;
        LOAD = 1'b1;
        tick("aclr_setup");
        #2;
        clear_pulse("aclr_now");
        #1;
        check_val("aclr_stay", Q, 16'h0000);
        LOAD = 1'b0;
        D    = 16'h5A5A;
        tick("aclr_noload");
        LOAD = 1'b1;
        tick("aclr_reload");
        check_val("aclr_final", Q, 16'h5A5A);

        // Load toggle
        LOAD = 1'b1;
        D    = 16'hA5A5;
        tick("toggle_n");
        LOAD = 1'b0;
        D    = 16'h5A5A;
        tick("toggle_n1");
        check_val("toggle_final", Q, 16'hA5A5);

        // Randomized traffic against the reference
        for (int k = 0; k < 300; k++) begin
            D    = 16'($urandom);
            LOAD = 1'($urandom_range(0, 1));
            #2;
            check_val("rnd_nocomb", Q, exp_q);
            D = 16'($urandom);
            if ($urandom_range(0, 15) == 0) clear_pulse("rnd_clr");
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
